// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - complementary PWM gate driver with dead time, double-buffered duty and latching fault
// Optional feature macro: PWM_MAX_DUTY_EN clamps every duty load at MAX_DUTY.
module pwm_gen #(
  parameter int CNT_W    = 8,
  parameter int DEAD_T   = 2,
  parameter int MAX_DUTY = 230
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_duty_sel,
  input  logic             i_fault,
  output logic             o_hs,
  output logic             o_ls,
  output logic             o_active,
  output logic             o_fault,
  output logic             o_period_start
);

  localparam int               DT_W      = (DEAD_T > 0) ? $clog2(DEAD_T + 1) : 1;
  localparam logic [DT_W-1:0]  DT_LOAD   = DT_W'(DEAD_T);
  localparam logic [DT_W-1:0]  DT_ONE    = DT_W'(1);
  localparam logic             NO_DEAD   = (DEAD_T == 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DUTY_CEIL = CNT_W'(MAX_DUTY);

`ifdef PWM_MAX_DUTY_EN
  localparam logic CLAMP_EN = 1'b1;
`else
  localparam logic CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_load;
  logic             raw;
  logic             raw_d;
  logic             raw_edge;
  logic [DT_W-1:0]  dt_cnt;

  // Duty value offered to the double buffer, clamped at the ceiling when that feature is built in
  always_comb begin
    duty_load = i_duty_sel;
    if (CLAMP_EN && (i_duty_sel > DUTY_CEIL)) begin
      duty_load = DUTY_CEIL;
    end
  end

  // Raw PWM compare and its transition against the previous cycle
  always_comb begin
    raw      = (cnt < duty_q);
    raw_edge = raw ^ raw_d;
  end

  // Mode control, period counter, duty double buffer and dead-banded gate drives
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      duty_q         <= '0;
      raw_d          <= 1'b0;
      dt_cnt         <= '0;
      o_hs           <= 1'b0;
      o_ls           <= 1'b0;
      o_active       <= 1'b0;
      o_fault        <= 1'b0;
      o_period_start <= 1'b0;
    end else begin
      o_hs           <= 1'b0;
      o_ls           <= 1'b0;
      o_period_start <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_fault) begin
            state   <= FAULT;
            o_fault <= 1'b1;
          end else if (i_enable) begin
            state          <= RUN;
            o_active       <= 1'b1;
            o_period_start <= 1'b1;
            duty_q         <= duty_load;
            // Seed raw_d with the first compare result so only the entry dead band applies
            raw_d          <= (duty_load != '0);
            dt_cnt         <= DT_LOAD;
          end
        end
        RUN: begin
          if (i_fault) begin
            state    <= FAULT;
            o_fault  <= 1'b1;
            o_active <= 1'b0;
            cnt      <= '0;
            dt_cnt   <= '0;
            raw_d    <= 1'b0;
          end else begin
            if (cnt == CNT_MAX) begin
              duty_q <= duty_load;
            end
            if (!i_enable) begin
              state    <= IDLE;
              o_active <= 1'b0;
              cnt      <= '0;
              dt_cnt   <= '0;
              raw_d    <= 1'b0;
            end else begin
              cnt            <= cnt + 1'b1;
              o_period_start <= (cnt == CNT_MAX);
              raw_d          <= raw;
              if (raw_edge) begin
                // dt_cnt counts blanked output cycles including the one driven now
                dt_cnt <= DT_LOAD;
                o_hs   <= NO_DEAD & raw;
                o_ls   <= NO_DEAD & ~raw;
              end else if (dt_cnt > DT_ONE) begin
                dt_cnt <= dt_cnt - DT_ONE;
              end else begin
                dt_cnt <= '0;
                o_hs   <= raw;
                o_ls   <= ~raw;
              end
            end
          end
        end
        FAULT: begin
          if (!i_enable && !i_fault) begin
            state   <= IDLE;
            o_fault <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - randomized and directed bench for pwm_gen against a window-based reference model
module tb_pwm_gen;

  localparam int CNT_W    = 8;
  localparam int DEAD_T   = 2;
  localparam int MAX_DUTY = 230;
  localparam int PERIOD   = 256;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_FAULT  = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic [CNT_W-1:0] dsel;
  logic             flt;
  logic             o_hs;
  logic             o_ls;
  logic             o_active;
  logic             o_fault;
  logic             o_period_start;

  always #5 clk = ~clk;

  pwm_gen #(
    .CNT_W   (CNT_W),
    .DEAD_T  (DEAD_T),
    .MAX_DUTY(MAX_DUTY)
  ) dut (
    .i_clk         (clk),
    .reset         (rstn),
    .i_enable      (en),
    .i_duty_sel    (dsel),
    .i_fault       (flt),
    .o_hs          (o_hs),
    .o_ls          (o_ls),
    .o_active      (o_active),
    .o_fault       (o_fault),
    .o_period_start(o_period_start)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode, position in period, buffered duty, recent raw samples of this run
  int m_mode  = M_IDLE;
  int m_phase = 0;
  int m_duty  = 0;
  bit m_win[$];
  bit e_hs    = 1'b0;
  bit e_ls    = 1'b0;

  int acc_hs = 0;
  int acc_ls = 0;
  int acc_ps = 0;

  function automatic int clamp_duty(input int d);
`ifdef PWM_MAX_DUTY_EN
    return (d > MAX_DUTY) ? MAX_DUTY : d;
`else
    return d;
`endif
  endfunction

  // A gate is on only when the last DEAD_T+1 raw samples agree (DEAD_T at the start of a run)
  task automatic model_edge(input bit e, input int d, input bit f, input bit r);
    bit cur;
    bit ok;
    e_hs = 1'b0;
    e_ls = 1'b0;
    if (!r) begin
      m_mode  = M_IDLE;
      m_phase = 0;
      m_duty  = 0;
      m_win.delete();
    end else if (m_mode == M_IDLE) begin
      if (f) begin
        m_mode = M_FAULT;
      end else if (e) begin
        m_mode  = M_RUN;
        m_duty  = clamp_duty(d);
        m_phase = 0;
        m_win.delete();
      end
    end else if (m_mode == M_RUN) begin
      if (f) begin
        m_mode  = M_FAULT;
        m_phase = 0;
        m_win.delete();
      end else begin
        cur = (m_phase < m_duty);
        if (m_phase == PERIOD - 1) m_duty = clamp_duty(d);
        if (!e) begin
          m_mode  = M_IDLE;
          m_phase = 0;
          m_win.delete();
        end else begin
          m_win.push_back(cur);
          if (m_win.size() > DEAD_T + 1) void'(m_win.pop_front());
          ok = (m_win.size() >= DEAD_T);
          foreach (m_win[i]) if (m_win[i] != cur) ok = 1'b0;
          e_hs    = ok & cur;
          e_ls    = ok & ~cur;
          m_phase = (m_phase + 1) % PERIOD;
        end
      end
    end else begin
      if (!e && !f) m_mode = M_IDLE;
    end
  endtask

  task automatic step(input bit e, input int d, input bit f, input bit r);
    en   = e;
    dsel = CNT_W'(d);
    flt  = f;
    rstn = r;
    @(posedge clk);
    model_edge(e, d, f, r);
    #1;
    check_eq("hs", int'(o_hs), int'(e_hs));
    check_eq("ls", int'(o_ls), int'(e_ls));
    check_eq("active", int'(o_active), int'(m_mode == M_RUN));
    check_eq("fault", int'(o_fault), int'(m_mode == M_FAULT));
    check_eq("period_start", int'(o_period_start), int'(m_mode == M_RUN && m_phase == 0));
    check_eq("overlap", int'(o_hs & o_ls), 0);
    acc_hs += int'(o_hs);
    acc_ls += int'(o_ls);
    acc_ps += int'(o_period_start);
  endtask

  task automatic run_n(input int n, input bit e, input int d, input bit f);
    for (int i = 0; i < n; i++) step(e, d, f, 1'b1);
  endtask

  task automatic clear_acc();
    acc_hs = 0;
    acc_ls = 0;
    acc_ps = 0;
  endtask

  initial begin
    en   = 1'b0;
    dsel = '0;
    flt  = 1'b0;
    rstn = 1'b0;

    // Reset state
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check_eq("rst_outputs", int'({o_hs, o_ls, o_active, o_fault, o_period_start}), 0);

    // Duty 128: steady period counts
    step(1'b1, 128, 1'b0, 1'b1);
    run_n(255, 1'b1, 128, 1'b0);
    clear_acc();
    run_n(256, 1'b1, 128, 1'b0);
    check_eq("t1_hs_count", acc_hs, 126);
    check_eq("t1_ls_count", acc_ls, 126);
    check_eq("t1_ps_count", acc_ps, 1);

    // Duty 64 changed to 192 mid-period
    step(1'b0, 64, 1'b0, 1'b1);
    step(1'b1, 64, 1'b0, 1'b1);
    run_n(255, 1'b1, 64, 1'b0);
    clear_acc();
    run_n(100, 1'b1, 64, 1'b0);
    run_n(156, 1'b1, 192, 1'b0);
    check_eq("t2_hs_old", acc_hs, 62);
    clear_acc();
    run_n(256, 1'b1, 192, 1'b0);
    check_eq("t2_hs_new", acc_hs, 190);

    // Duty 0 from IDLE
    step(1'b0, 0, 1'b0, 1'b1);
    clear_acc();
    step(1'b1, 0, 1'b0, 1'b1);
    run_n(299, 1'b1, 0, 1'b0);
    check_eq("t3_hs_count", acc_hs, 0);
    check_eq("t3_ls_count", acc_ls, 298);

    // Fault while high side is on, then staged release
    step(1'b0, 128, 1'b0, 1'b1);
    step(1'b1, 128, 1'b0, 1'b1);
    run_n(49, 1'b1, 128, 1'b0);
    check_eq("t4_hs_before", int'(o_hs), 1);
    step(1'b1, 128, 1'b1, 1'b1);
    check_eq("t4_gates_off", int'({o_hs, o_ls}), 0);
    check_eq("t4_fault_set", int'(o_fault), 1);
    check_eq("t4_inactive", int'(o_active), 0);
    step(1'b1, 128, 1'b0, 1'b1);
    check_eq("t4_fault_held", int'(o_fault), 1);
    step(1'b0, 128, 1'b0, 1'b1);
    check_eq("t4_fault_clear", int'(o_fault), 0);

    // Reset mid-RUN, then restart
    step(1'b1, 128, 1'b0, 1'b1);
    run_n(50, 1'b1, 128, 1'b0);
    step(1'b1, 128, 1'b0, 1'b0);
    check_eq("t5_rst_outputs", int'({o_hs, o_ls, o_active, o_fault, o_period_start}), 0);
    step(1'b0, 128, 1'b0, 1'b1);
    step(1'b1, 128, 1'b0, 1'b1);
    check_eq("t5_first_ps", int'(o_period_start), 1);
    check_eq("t5_dead0", int'({o_hs, o_ls}), 0);
    step(1'b1, 128, 1'b0, 1'b1);
    check_eq("t5_dead1", int'({o_hs, o_ls}), 0);
    step(1'b1, 128, 1'b0, 1'b1);
    check_eq("t5_hs_on", int'(o_hs), 1);

    // Duty 255: ceiling or swallowed low pulse
    step(1'b0, 255, 1'b0, 1'b1);
    step(1'b1, 255, 1'b0, 1'b1);
    run_n(255, 1'b1, 255, 1'b0);
    clear_acc();
    run_n(256, 1'b1, 255, 1'b0);
`ifdef PWM_MAX_DUTY_EN
    check_eq("t6_hs_count", acc_hs, 228);
    check_eq("t6_ls_count", acc_ls, 24);
`else
    check_eq("t6_hs_count", acc_hs, 253);
    check_eq("t6_ls_count", acc_ls, 0);
`endif

    // Randomized episodes checked cycle by cycle against the model
    for (int ep = 0; ep < 40; ep++) begin
      int len;
      int duty;
      len = $urandom_range(700, 50);
      case ($urandom_range(6, 0))
        0:       duty = 0;
        1:       duty = 1;
        2:       duty = 2;
        3:       duty = 254;
        4:       duty = 255;
        default: duty = $urandom_range(255, 0);
      endcase
      if ($urandom_range(9, 0) == 0) step(1'b0, duty, 1'b0, 1'b0);
      for (int c = 0; c < len; c++) begin
        bit f;
        bit e;
        f = ($urandom_range(399, 0) == 0);
        e = ($urandom_range(299, 0) != 0);
        if ($urandom_range(79, 0) == 0) duty = $urandom_range(255, 0);
        if ($urandom_range(999, 0) == 0) step(e, duty, f, 1'b0);
        else step(e, duty, f, 1'b1);
      end
      run_n($urandom_range(5, 1), 1'b0, duty, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
